// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/checker block.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEFAULT_DATA_W = 7;
  localparam int unsigned DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/parity_core.sv
// Combinational parity bit: XOR-reduce of the word folded with the mode bit.
module parity_core #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic         cbit_i,
  output logic         p_o
);

  assign p_o = (^data_i) ^ cbit_i;

endmodule

// File: rtl/parity_gen_check.sv
// Registered parity generator (TX side) and parity checker with saturating error tally (RX side).
module parity_gen_check
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cbit_i,
  input  logic              gen_valid_i,
  input  logic [DATA_W-1:0] gen_data_i,
  input  logic              chk_valid_i,
  input  logic [DATA_W:0]   chk_data_i,
  input  logic              cnt_clr_i,
  output logic              gen_out_valid_o,
  output logic              gen_par_o,
  output logic [DATA_W:0]   gen_word_o,
  output logic              chk_out_valid_o,
  output logic              chk_err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  logic gen_p, chk_p;

  parity_core #(
    .W(DATA_W)
  ) u_gen_core (
    .data_i(gen_data_i),
    .cbit_i(cbit_i),
    .p_o   (gen_p)
  );

  parity_core #(
    .W(DATA_W + 1)
  ) u_chk_core (
    .data_i(chk_data_i),
    .cbit_i(cbit_i),
    .p_o   (chk_p)
  );

  logic              gen_valid_q;
  logic [DATA_W:0]   gen_word_q, gen_word_d;
  logic              chk_valid_q;
  logic              chk_err_q, chk_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    gen_word_d = gen_word_q;
    chk_err_d  = chk_err_q;
    err_cnt_d  = err_cnt_q;
    if (gen_valid_i) gen_word_d = {gen_p, gen_data_i};
    if (chk_valid_i) chk_err_d = chk_p;
    // Clear wins over a same-cycle error; the error event is dropped.
    if (cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (chk_valid_i && chk_p && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gen_valid_q <= 1'b0;
      gen_word_q  <= '0;
      chk_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      gen_valid_q <= gen_valid_i;
      gen_word_q  <= gen_word_d;
      chk_valid_q <= chk_valid_i;
      chk_err_q   <= chk_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign gen_out_valid_o = gen_valid_q;
  assign gen_par_o       = gen_word_q[DATA_W];
  assign gen_word_o      = gen_word_q;
  assign chk_out_valid_o = chk_valid_q;
  assign chk_err_o       = chk_err_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_parity_gen_check.sv
// Directed bench for parity_gen_check; a second instance with a 2-bit counter checks saturation.
module tb_parity_gen_check;

  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cbit;
  logic          gen_valid;
  logic [DW-1:0] gen_data;
  logic          chk_valid;
  logic [DW:0]   chk_data;
  logic          cnt_clr;

  logic          gen_out_valid, gen_par, chk_out_valid, chk_err;
  logic [DW:0]   gen_word;
  logic [15:0]   err_cnt;

  logic          s_gen_out_valid, s_gen_par, s_chk_out_valid, s_chk_err;
  logic [DW:0]   s_gen_word;
  logic [1:0]    s_err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt;
  logic [DW:0] held_word;

  always #5 clk = ~clk;

  parity_gen_check #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .cbit_i(cbit),
    .gen_valid_i(gen_valid), .gen_data_i(gen_data),
    .chk_valid_i(chk_valid), .chk_data_i(chk_data), .cnt_clr_i(cnt_clr),
    .gen_out_valid_o(gen_out_valid), .gen_par_o(gen_par), .gen_word_o(gen_word),
    .chk_out_valid_o(chk_out_valid), .chk_err_o(chk_err), .err_cnt_o(err_cnt)
  );

  parity_gen_check #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .cbit_i(cbit),
    .gen_valid_i(gen_valid), .gen_data_i(gen_data),
    .chk_valid_i(chk_valid), .chk_data_i(chk_data), .cnt_clr_i(cnt_clr),
    .gen_out_valid_o(s_gen_out_valid), .gen_par_o(s_gen_par), .gen_word_o(s_gen_word),
    .chk_out_valid_o(s_chk_out_valid), .chk_err_o(s_chk_err), .err_cnt_o(s_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic par_of(input logic [31:0] v, input logic m);
    return logic'($countones(v) % 2) ^ m;
  endfunction

  initial begin
    rst = 1'b1; cbit = 1'b0; gen_valid = 1'b0; gen_data = '0;
    chk_valid = 1'b0; chk_data = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gen_out_valid", gen_out_valid, 0);
    check("rst_gen_word", gen_word, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    step();

    // Hand-computed generator examples
    gen_valid = 1'b1; gen_data = 7'h00; cbit = 1'b0; step();
    check("gen_00_even_valid", gen_out_valid, 1);
    check("gen_00_even_par", gen_par, 0);
    check("gen_00_even_word", gen_word, 8'h00);
    cbit = 1'b1; step();
    check("gen_00_odd_par", gen_par, 1);
    check("gen_00_odd_word", gen_word, 8'h80);
    gen_data = 7'h07; cbit = 1'b0; step();
    check("gen_07_even_par", gen_par, 1);
    check("gen_07_even_word", gen_word, 8'h87);

    // Generator sweep, both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 128; i++) begin
        gen_data = i[DW-1:0]; cbit = m[0]; step();
        check("gen_sweep_par", gen_par, par_of(i, m[0]));
        check("gen_sweep_word", gen_word, {par_of(i, m[0]), i[DW-1:0]});
      end
    end
    gen_valid = 1'b0;

    // Hand-computed checker examples
    chk_valid = 1'b1; chk_data = 8'h03; cbit = 1'b0; step();
    check("chk_03_even_valid", chk_out_valid, 1);
    check("chk_03_even", chk_err, 0);
    cbit = 1'b1; step();
    check("chk_03_odd", chk_err, 1);
    chk_data = 8'h80; step();
    check("chk_80_odd", chk_err, 0);
    check("chk_examples_cnt", err_cnt, 1);
    exp_cnt = 1;

    // Checker sweep, both modes; 128 errors per mode
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) begin
        chk_data = i[DW:0]; cbit = m[0]; step();
        check("chk_sweep_err", chk_err, par_of(i, m[0]));
        if (par_of(i, m[0])) exp_cnt++;
      end
    end
    check("chk_sweep_cnt", err_cnt, exp_cnt);
    check("chk_sweep_cnt_sat", s_err_cnt, 3);

    // Clear together with a bad word drops the event
    chk_data = 8'h01; cbit = 1'b0; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0;
    check("clr_prio_cnt", err_cnt, 0);
    check("clr_prio_cnt_sat", s_err_cnt, 0);
    check("clr_prio_err", chk_err, 1);

    // Five bad words
    repeat (5) step();
    check("cnt_five", err_cnt, 5);
    chk_data = 8'h01; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0;
    check("cnt_clr_bad", err_cnt, 0);
    repeat (6) step();
    check("cnt_six", err_cnt, 6);
    check("cnt_sat_three", s_err_cnt, 3);

    // Valid gating on the checker path: last result was an error
    chk_valid = 1'b0; chk_data = 8'h00; step();
    check("gate_chk_valid", chk_out_valid, 0);
    check("gate_chk_err_hold", chk_err, 1);
    chk_data = 8'h01; step();
    check("gate_cnt_hold", err_cnt, 6);

    // Valid gating on the generator path
    gen_valid = 1'b1; gen_data = 7'h55; cbit = 1'b1; step();
    held_word = {1'b1 ^ 1'b0, 7'h55}; // 0x55 has four 1s
    check("gate_gen_load", gen_word, held_word);
    gen_valid = 1'b0; gen_data = 7'h2a; cbit = 1'b0; step();
    check("gate_gen_valid", gen_out_valid, 0);
    check("gate_gen_word_hold", gen_word, held_word);

    // Loopback: generated word checks clean under the same mode
    exp_cnt = 6;
    for (int k = 0; k < 8; k++) begin
      gen_valid = 1'b1; chk_valid = 1'b0; gen_data = 7'(k * 19 + 3); cbit = k[0]; step();
      gen_valid = 1'b0; chk_valid = 1'b1; chk_data = gen_word; step();
      check("loop_err", chk_err, 0);
    end
    chk_valid = 1'b0;
    check("loop_cnt", err_cnt, exp_cnt);

    // Asynchronous reset mid-stream, both paths active
    gen_valid = 1'b1; gen_data = 7'h01; chk_valid = 1'b1; chk_data = 8'h01; cbit = 1'b0;
    step();
    check("pre_rst_cnt", err_cnt, 7);
    #2 rst = 1'b1;
    #1;
    check("arst_gen_out_valid", gen_out_valid, 0);
    check("arst_gen_par", gen_par, 0);
    check("arst_gen_word", gen_word, 0);
    check("arst_chk_out_valid", chk_out_valid, 0);
    check("arst_chk_err", chk_err, 0);
    check("arst_err_cnt", err_cnt, 0);
    gen_valid = 1'b0; chk_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_cnt", err_cnt, 0);
    check("post_rst_chk_valid", chk_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
